// File: rtl/microcode_sequencer.sv
// Microcode sequencer: opcode decode, variable-length microstep table,
// falling-edge control word, rising-edge flags, sticky halt.
module microcode_sequencer #(
    parameter int OPCODE_W = 4,
    parameter int INSN_W   = 8,
    parameter int STEP_W   = 3,
    parameter int MAX_STEP = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INSN_W-1:0] insn,
    input  logic              prog_mode,
    input  logic              carry_in,
    input  logic              zero_in,
    output logic [15:0]       cw,
    output logic [STEP_W-1:0] step,
    output logic              carry_flag,
    output logic              zero_flag,
    output logic              halted
);
    localparam logic [15:0] HLT = 16'h8000;
    localparam logic [15:0] MI  = 16'h4000;
    localparam logic [15:0] RI  = 16'h2000;
    localparam logic [15:0] RO  = 16'h1000;
    localparam logic [15:0] IO  = 16'h0800;
    localparam logic [15:0] II  = 16'h0400;
    localparam logic [15:0] AI  = 16'h0200;
    localparam logic [15:0] AO  = 16'h0100;
    localparam logic [15:0] EO  = 16'h0080;
    localparam logic [15:0] SU  = 16'h0040;
    localparam logic [15:0] BI  = 16'h0020;
    localparam logic [15:0] OI  = 16'h0010;
    localparam logic [15:0] CE  = 16'h0008;
    localparam logic [15:0] CO  = 16'h0004;
    localparam logic [15:0] J   = 16'h0002;
    localparam logic [15:0] FI  = 16'h0001;
    localparam logic [15:0] FETCH = MI | CO;

    typedef enum logic [1:0] {
        S_RUN,
        S_PROG,
        S_HALT
    } mode_t;

    mode_t               mode;
    mode_t               mode_nxt;
    logic [15:0]         cw_nxt;
    logic [STEP_W-1:0]   step_nxt;
    logic [STEP_W-1:0]   step_inc;
    logic [OPCODE_W-1:0] op;
    logic [3:0]          op_lo;
    logic                op_hi_zero;
    logic                is2;
    logic                is3;
    logic                is4;
    logic [15:0]         entry;
    logic                unused_operand;

    assign op             = insn[INSN_W-1 -: OPCODE_W];
    assign op_lo          = op[3:0];
    assign op_hi_zero     = (op >> 4) == '0;
    assign unused_operand = ^insn[INSN_W-OPCODE_W-1:0];
    assign step_inc       = step + 1'b1;
    assign is2            = step_inc == STEP_W'(2);
    assign is3            = step_inc == STEP_W'(3);
    assign is4            = step_inc == STEP_W'(4);
    assign halted         = mode == S_HALT;

    // Every real entry is nonzero, so an all-zero word marks end of insn.
    always_comb begin
        entry = '0;
        if (op_hi_zero) begin
            case (op_lo)
                4'h1: entry = is2 ? (MI | IO) : is3 ? (RO | AI) : '0;
                4'h2: entry = is2 ? (MI | IO) : is3 ? (RO | BI) :
                              is4 ? (EO | AI | FI) : '0;
                4'h3: entry = is2 ? (MI | IO) : is3 ? (RO | BI) :
                              is4 ? (EO | SU | AI | FI) : '0;
                4'h4: entry = is2 ? (MI | IO) : is3 ? (AO | RI) : '0;
                4'h5: entry = is2 ? (IO | AI) : '0;
                4'h6: entry = is2 ? (IO | J) : '0;
                4'h7: entry = (is2 && carry_flag) ? (IO | J) : '0;
                4'h8: entry = (is2 && zero_flag) ? (IO | J) : '0;
                4'hE: entry = is2 ? (AO | OI) : '0;
                4'hF: entry = is2 ? HLT : '0;
                default: entry = '0;
            endcase
        end
    end

    always_comb begin
        mode_nxt = mode;
        cw_nxt   = cw;
        step_nxt = step;
        priority case (1'b1)
            mode == S_HALT: begin
            end
            prog_mode: begin
                mode_nxt = S_PROG;
                cw_nxt   = HLT;
                step_nxt = '0;
            end
            mode == S_PROG: begin
                mode_nxt = S_RUN;
                cw_nxt   = FETCH;
                step_nxt = '0;
            end
            step == STEP_W'(MAX_STEP): begin
                cw_nxt   = FETCH;
                step_nxt = '0;
            end
            step == '0: begin
                cw_nxt   = RO | II | CE;
                step_nxt = step_inc;
            end
            entry != '0: begin
                cw_nxt   = entry;
                step_nxt = step_inc;
                if (entry == HLT) mode_nxt = S_HALT;
            end
            default: begin
                cw_nxt   = FETCH;
                step_nxt = '0;
            end
        endcase
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            mode <= S_RUN;
            cw   <= FETCH;
            step <= '0;
        end else begin
            mode <= mode_nxt;
            cw   <= cw_nxt;
            step <= step_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_flag <= 1'b0;
            zero_flag  <= 1'b0;
        end else if (cw[0]) begin
            carry_flag <= carry_in;
            zero_flag  <= zero_in;
        end
    end
endmodule

// File: tb/tb_microcode_sequencer.sv
// Bench for microcode_sequencer: directed scenarios plus random
// instruction streams checked against a per-opcode sequence model.
module tb_microcode_sequencer;
    localparam logic [15:0] HLT = 16'h8000;
    localparam logic [15:0] MI  = 16'h4000;
    localparam logic [15:0] RI  = 16'h2000;
    localparam logic [15:0] RO  = 16'h1000;
    localparam logic [15:0] IO  = 16'h0800;
    localparam logic [15:0] II  = 16'h0400;
    localparam logic [15:0] AI  = 16'h0200;
    localparam logic [15:0] AO  = 16'h0100;
    localparam logic [15:0] EO  = 16'h0080;
    localparam logic [15:0] SU  = 16'h0040;
    localparam logic [15:0] BI  = 16'h0020;
    localparam logic [15:0] OI  = 16'h0010;
    localparam logic [15:0] CE  = 16'h0008;
    localparam logic [15:0] CO  = 16'h0004;
    localparam logic [15:0] J   = 16'h0002;
    localparam logic [15:0] FI  = 16'h0001;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  insn = 8'h00;
    logic        prog_mode = 1'b0;
    logic        carry_in = 1'b0;
    logic        zero_in = 1'b0;
    logic [15:0] cw;
    logic [2:0]  step;
    logic        carry_flag;
    logic        zero_flag;
    logic        halted;

    int          total = 0;
    int          bad = 0;
    logic        m_c = 1'b0;
    logic        m_z = 1'b0;
    logic [15:0] exp_q[$];

    microcode_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .insn       (insn),
        .prog_mode  (prog_mode),
        .carry_in   (carry_in),
        .zero_in    (zero_in),
        .cw         (cw),
        .step       (step),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic edge_chk(input string tag, input logic [15:0] ecw,
                            input int estep);
        @(negedge clk);
        #2;
        chk(tag, cw, ecw);
        chk({tag, "_step"}, 16'(step), 16'(estep));
    endtask

    task automatic chk_flags(input string tag, input logic c, input logic z);
        chk({tag, "_c"}, 16'(carry_flag), 16'(c));
        chk({tag, "_z"}, 16'(zero_flag), 16'(z));
    endtask

    // Expected words after fetch: the common decode word, then the opcode's list.
    task automatic run_model(input logic [7:0] ins, input logic ci,
                             input logic zi);
        logic [3:0] op;
        op = ins[7:4];
        insn = ins;
        carry_in = ci;
        zero_in = zi;
        exp_q = {};
        exp_q.push_back(RO | II | CE);
        case (op)
            4'h1: begin exp_q.push_back(MI | IO); exp_q.push_back(RO | AI); end
            4'h2: begin
                exp_q.push_back(MI | IO);
                exp_q.push_back(RO | BI);
                exp_q.push_back(EO | AI | FI);
            end
            4'h3: begin
                exp_q.push_back(MI | IO);
                exp_q.push_back(RO | BI);
                exp_q.push_back(EO | SU | AI | FI);
            end
            4'h4: begin exp_q.push_back(MI | IO); exp_q.push_back(AO | RI); end
            4'h5: exp_q.push_back(IO | AI);
            4'h6: exp_q.push_back(IO | J);
            4'h7: if (m_c) exp_q.push_back(IO | J);
            4'h8: if (m_z) exp_q.push_back(IO | J);
            4'hE: exp_q.push_back(AO | OI);
            default: ;
        endcase
        foreach (exp_q[i]) begin
            @(negedge clk);
            #2;
            chk("rnd_cw", cw, exp_q[i]);
            chk("rnd_step", 16'(step), 16'(i + 1));
        end
        if (op == 4'h2 || op == 4'h3) begin
            m_c = ci;
            m_z = zi;
        end
        edge_chk("rnd_end", MI | CO, 0);
        chk_flags("rnd_flags", m_c, m_z);
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        chk("rst_cw", cw, 16'h4004);
        chk("rst_step", 16'(step), 16'd0);
        chk("rst_halted", 16'(halted), 16'd0);
        chk_flags("rst_flags", 1'b0, 1'b0);
        #14 rst = 1'b0;
        #1;
        chk("rel_cw", cw, 16'h4004);
        chk("rel_step", 16'(step), 16'd0);

        insn = 8'h1E;
        edge_chk("lda1", 16'h1408, 1);
        edge_chk("lda2", 16'h4800, 2);
        edge_chk("lda3", 16'h1200, 3);
        edge_chk("lda0", 16'h4004, 0);

        insn = 8'h2F;
        carry_in = 1'b1;
        zero_in = 1'b0;
        edge_chk("add1", 16'h1408, 1);
        edge_chk("add2", 16'h4800, 2);
        edge_chk("add3", 16'h1020, 3);
        edge_chk("add4", 16'h0281, 4);
        @(posedge clk);
        #1;
        chk_flags("add_flags", 1'b1, 1'b0);
        edge_chk("add0", 16'h4004, 0);

        insn = 8'h73;
        edge_chk("jc_t1", 16'h1408, 1);
        edge_chk("jc_t2", 16'h0802, 2);
        edge_chk("jc_t0", 16'h4004, 0);

        insn = 8'h3F;
        carry_in = 1'b0;
        zero_in = 1'b1;
        edge_chk("sub1", 16'h1408, 1);
        edge_chk("sub2", 16'h4800, 2);
        edge_chk("sub3", 16'h1020, 3);
        edge_chk("sub4", 16'h02C1, 4);
        edge_chk("sub0", 16'h4004, 0);
        chk_flags("sub_flags", 1'b0, 1'b1);

        insn = 8'h73;
        edge_chk("jc_n1", 16'h1408, 1);
        edge_chk("jc_n0", 16'h4004, 0);

        insn = 8'h85;
        edge_chk("jz_t1", 16'h1408, 1);
        edge_chk("jz_t2", 16'h0802, 2);
        edge_chk("jz_t0", 16'h4004, 0);

        insn = 8'h2F;
        carry_in = 1'b0;
        zero_in = 1'b0;
        edge_chk("pg1", 16'h1408, 1);
        edge_chk("pg2", 16'h4800, 2);
        edge_chk("pg3", 16'h1020, 3);
        prog_mode = 1'b1;
        edge_chk("pg_hold1", 16'h8000, 0);
        chk("pg_halted", 16'(halted), 16'd0);
        edge_chk("pg_hold2", 16'h8000, 0);
        prog_mode = 1'b0;
        edge_chk("pg_res0", 16'h4004, 0);
        edge_chk("pg_res1", 16'h1408, 1);
        edge_chk("pg_res2", 16'h4800, 2);
        edge_chk("pg_res3", 16'h1020, 3);
        edge_chk("pg_res4", 16'h0281, 4);
        edge_chk("pg_res0b", 16'h4004, 0);
        m_c = 1'b0;
        m_z = 1'b0;
        chk_flags("pg_flags", m_c, m_z);

        for (int n = 0; n < 40; n++) begin
            logic [7:0] ins;
            ins = 8'($urandom_range(0, 255));
            ins[7:4] = 4'($urandom_range(0, 14));
            run_model(ins, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        insn = 8'hF0;
        edge_chk("hlt1", 16'h1408, 1);
        edge_chk("hlt2", 16'h8000, 2);
        chk("hlt_halted", 16'(halted), 16'd1);
        for (int k = 0; k < 10; k++) begin
            prog_mode = ~prog_mode;
            edge_chk("hlt_frz", 16'h8000, 2);
            chk("hlt_frz_h", 16'(halted), 16'd1);
        end
        prog_mode = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("hrst_cw", cw, 16'h4004);
        chk("hrst_step", 16'(step), 16'd0);
        chk("hrst_halted", 16'(halted), 16'd0);
        chk_flags("hrst_flags", 1'b0, 1'b0);
        #5 rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
